// File: rtl/rr_lock_arbiter_pkg.sv
// rr_lock_arbiter_pkg: shared state type and index helpers for the round-robin lock arbiter
package rr_lock_arbiter_pkg;
  localparam int MAX_N = 64;
  localparam int SCAN_W = 2 * MAX_N;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // Lowest set bit of a rotated double-width request vector, folded back into 0..n-1.
  function automatic int rr_index(input logic [SCAN_W-1:0] masked, input int n);
    int k;
    k = 0;
    for (int i = SCAN_W - 1; i >= 0; i--) if (masked[i]) k = i;
    return k >= n ? k - n : k;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick of the first request at or after ptr
module rr_pick import rr_lock_arbiter_pkg::*; #(
  parameter int N_IN = 4,
  localparam int IDX_W = idx_w(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_IN-1:0]  gnt,
  output logic [IDX_W-1:0] idx
);
  logic [2*N_IN-1:0] masked;
  always_comb begin
    masked = {req, req} & ({(2*N_IN){1'b1}} << ptr);
    idx = IDX_W'(rr_index(SCAN_W'(masked), N_IN));
    gnt = |req ? N_IN'(1) << idx : '0;
  end
endmodule

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: N-input round-robin arbiter with burst locking and a registered output stage
module rr_lock_arbiter import rr_lock_arbiter_pkg::*; #(
  parameter int N_IN = 4,
  parameter int DATA_W = 64,
  localparam int IDX_W = idx_w(N_IN)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_IN-1:0]          io_in_valid,
  output logic [N_IN-1:0]          io_in_ready,
  input  logic [N_IN*DATA_W-1:0]   io_in_bits_data,
  input  logic [N_IN-1:0]          io_in_bits_last,
  output logic                     io_out_valid,
  input  logic                     io_out_ready,
  output logic [DATA_W-1:0]        io_out_bits_data,
  output logic                     io_out_bits_last,
  output logic [IDX_W-1:0]         io_chosen
);
  arb_state_e state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt, lock_idx, lock_nxt, gidx, sel;
  logic [N_IN-1:0] gnt;
  logic acc, fire, sel_last;
  logic [DATA_W-1:0] sel_data;
  rr_pick #(.N_IN(N_IN)) u_pick (
    .req(io_in_valid),
    .ptr(ptr),
    .gnt(gnt),
    .idx(gidx)
  );
  // Readiness never looks at payload or last, only at valids, out_ready and the lock.
  always_comb begin
    acc = !io_out_valid || io_out_ready;
    sel = state == LOCKED ? lock_idx : gidx;
    io_in_ready = (!reset || !acc) ? '0 : state == LOCKED ? N_IN'(1) << lock_idx : gnt;
    fire = |(io_in_valid & io_in_ready);
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N_IN; i++)
      if (sel == IDX_W'(i)) begin
        sel_data = io_in_bits_data[i*DATA_W +: DATA_W];
        sel_last = io_in_bits_last[i];
      end
    state_nxt = state;
    ptr_nxt = ptr;
    lock_nxt = lock_idx;
    if (fire) begin
      state_nxt = sel_last ? IDLE : LOCKED;
      ptr_nxt = !sel_last ? ptr : sel == IDX_W'(N_IN - 1) ? '0 : sel + 1'b1;
      lock_nxt = sel_last ? lock_idx : sel;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      lock_idx <= '0;
      io_out_valid <= 1'b0;
      io_out_bits_data <= '0;
      io_out_bits_last <= 1'b0;
      io_chosen <= '0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      lock_idx <= lock_nxt;
      if (fire) begin
        io_out_valid <= 1'b1;
        io_out_bits_data <= sel_data;
        io_out_bits_last <= sel_last;
        io_chosen <= sel;
      end else if (io_out_ready) io_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb_rr_lock_arbiter: three arbiter instances (N_IN=4/3/1) checked against a behavioural model
module tb_rr_lock_arbiter;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;
  int n_vec = 0, n_err = 0;
  logic [3:0] v_in[3], l_in[3];
  logic r_in[3];
  logic [63:0] d_in[3][4];
  logic [3:0] a_rdy;
  logic a_ov, a_ol;
  logic [63:0] a_od;
  logic [1:0] a_oc;
  logic [2:0] b_rdy;
  logic b_ov, b_ol;
  logic [15:0] b_od;
  logic [1:0] b_oc;
  logic c_rdy, c_ov, c_ol, c_oc;
  logic [7:0] c_od;
  rr_lock_arbiter #(.N_IN(4), .DATA_W(64)) u_a (
    .clock(clock), .reset(reset), .io_in_valid(v_in[0]), .io_in_ready(a_rdy),
    .io_in_bits_data({d_in[0][3], d_in[0][2], d_in[0][1], d_in[0][0]}), .io_in_bits_last(l_in[0]),
    .io_out_valid(a_ov), .io_out_ready(r_in[0]), .io_out_bits_data(a_od), .io_out_bits_last(a_ol),
    .io_chosen(a_oc));
  rr_lock_arbiter #(.N_IN(3), .DATA_W(16)) u_b (
    .clock(clock), .reset(reset), .io_in_valid(v_in[1][2:0]), .io_in_ready(b_rdy),
    .io_in_bits_data({d_in[1][2][15:0], d_in[1][1][15:0], d_in[1][0][15:0]}), .io_in_bits_last(l_in[1][2:0]),
    .io_out_valid(b_ov), .io_out_ready(r_in[1]), .io_out_bits_data(b_od), .io_out_bits_last(b_ol),
    .io_chosen(b_oc));
  rr_lock_arbiter #(.N_IN(1), .DATA_W(8)) u_c (
    .clock(clock), .reset(reset), .io_in_valid(v_in[2][0]), .io_in_ready(c_rdy),
    .io_in_bits_data(d_in[2][0][7:0]), .io_in_bits_last(l_in[2][0]),
    .io_out_valid(c_ov), .io_out_ready(r_in[2]), .io_out_bits_data(c_od), .io_out_bits_last(c_ol),
    .io_chosen(c_oc));
  logic [3:0] rdy_act[3];
  logic [67:0] out_act[3];
  assign rdy_act[0] = a_rdy;
  assign rdy_act[1] = {1'b0, b_rdy};
  assign rdy_act[2] = {3'b0, c_rdy};
  assign out_act[0] = {a_ov, a_ol, a_oc, a_od};
  assign out_act[1] = {b_ov, b_ol, b_oc, 48'b0, b_od};
  assign out_act[2] = {c_ov, c_ol, 1'b0, c_oc, 56'b0, c_od};
  // Reference model: pointer, lock and output register per instance, by the arbitration rules.
  int m_ptr[3], m_li[3], m_oc[3];
  logic m_lk[3], m_ov[3], m_ol[3];
  logic [63:0] m_od[3];
  function automatic int nin(int k);
    return k == 0 ? 4 : k == 1 ? 3 : 1;
  endfunction
  function automatic logic [63:0] rdata(int k);
    return k == 0 ? {$urandom, $urandom} : k == 1 ? 64'($urandom_range(0, 65535)) : 64'($urandom_range(0, 255));
  endfunction
  function automatic logic [3:0] model_ready(int k);
    int n, i;
    n = nin(k);
    if (m_ov[k] && !r_in[k]) return 4'b0;
    if (m_lk[k]) return 4'(1 << m_li[k]);
    for (int j = 0; j < n; j++) begin
      i = (m_ptr[k] + j) % n;
      if (v_in[k][i]) return 4'(1 << i);
    end
    return 4'b0;
  endfunction
  function automatic logic [67:0] exp_out(int k);
    return {m_ov[k], m_ol[k], 2'(m_oc[k]), m_od[k]};
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ptr[k] = 0; m_li[k] = 0; m_oc[k] = 0; m_lk[k] = 0; m_ov[k] = 0; m_ol[k] = 0; m_od[k] = '0;
    end
  endtask
  task automatic model_clock(int k);
    logic [3:0] r;
    r = model_ready(k);
    if ((r & v_in[k]) != 4'b0) begin
      for (int i = 0; i < 4; i++)
        if (r[i]) begin
          m_ov[k] = 1; m_od[k] = d_in[k][i]; m_ol[k] = l_in[k][i]; m_oc[k] = i;
          if (l_in[k][i]) begin m_ptr[k] = (i + 1) % nin(k); m_lk[k] = 0; end
          else begin m_lk[k] = 1; m_li[k] = i; end
        end
    end else if (r_in[k]) m_ov[k] = 0;
  endtask
  task automatic advance();
    for (int k = 0; k < 3; k++) model_clock(k);
    @(posedge clock);
    @(negedge clock);
  endtask
  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      v_in[k] = 4'b0; l_in[k] = 4'b0; r_in[k] = 1'b1;
      for (int i = 0; i < 4; i++) d_in[k][i] = '0;
    end
  endtask
  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin v_in[k] = 4'((1 << nin(k)) - 1); l_in[k] = 4'hF; end
    #1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (rdy_act[k] !== 4'b0) begin n_err++; $display("FAIL reset_ready[%0d] got %b want 0000", k, rdy_act[k]); end
      n_vec++;
      if (out_act[k] !== 68'b0) begin n_err++; $display("FAIL reset_out[%0d] got %h want 0", k, out_act[k]); end
    end
    reset = 1'b1;
    idle_all();
    advance();
  endtask
  task automatic test_round_robin();
    logic [3:0] er;
    v_in[0] = 4'hF; l_in[0] = 4'hF; r_in[0] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 4; i++) d_in[0][i] = rdata(0);
      #1; er = model_ready(0);
      n_vec++;
      if (rdy_act[0] !== er) begin n_err++; $display("FAIL rr_ready got %b want %b", rdy_act[0], er); end
      advance();
      n_vec++;
      if (out_act[0] !== exp_out(0)) begin n_err++; $display("FAIL rr_out got %h want %h", out_act[0], exp_out(0)); end
      n_vec++;
      if ({a_ov, a_oc} !== {1'b1, 2'(j % 4)}) begin n_err++; $display("FAIL rr_chosen beat %0d got %b%0d want 1%0d", j, a_ov, a_oc, j % 4); end
    end
    idle_all();
    advance();
  endtask
  task automatic test_burst();
    logic [3:0] tv[8] = '{4'b0010, 4'b0111, 4'b0101, 4'b0101, 4'b0111, 4'b0101, 4'b0101, 4'b0000};
    logic [3:0] tl[8] = '{4'b0000, 4'b0101, 4'b0101, 4'b0101, 4'b0111, 4'b0101, 4'b0101, 4'b0000};
    logic [2:0] texp[8] = '{3'b101, 3'b101, 3'b001, 3'b001, 3'b101, 3'b110, 3'b100, 3'b000};
    logic [3:0] er;
    for (int j = 0; j < 8; j++) begin
      v_in[0] = tv[j]; l_in[0] = tl[j]; r_in[0] = 1'b1;
      for (int i = 0; i < 4; i++) d_in[0][i] = rdata(0);
      #1; er = model_ready(0);
      n_vec++;
      if (rdy_act[0] !== er) begin n_err++; $display("FAIL burst_ready cyc %0d got %b want %b", j, rdy_act[0], er); end
      advance();
      n_vec++;
      if (out_act[0] !== exp_out(0)) begin n_err++; $display("FAIL burst_out cyc %0d got %h want %h", j, out_act[0], exp_out(0)); end
      n_vec++;
      if ({a_ov, a_oc} !== texp[j]) begin n_err++; $display("FAIL burst_seq cyc %0d got %b want %b", j, {a_ov, a_oc}, texp[j]); end
    end
    idle_all();
  endtask
  task automatic test_backpressure();
    logic [3:0] er;
    v_in[0] = 4'hF; l_in[0] = 4'hF;
    for (int j = 0; j < 7; j++) begin
      r_in[0] = j == 0 || j == 6;
      for (int i = 0; i < 4; i++) d_in[0][i] = rdata(0);
      #1; er = model_ready(0);
      n_vec++;
      if (rdy_act[0] !== er) begin n_err++; $display("FAIL bp_ready cyc %0d got %b want %b", j, rdy_act[0], er); end
      n_vec++;
      if (j > 0 && j < 6 && rdy_act[0] !== 4'b0) begin n_err++; $display("FAIL bp_stall cyc %0d got %b want 0000", j, rdy_act[0]); end
      else if (j == 6 && rdy_act[0] !== 4'b0100) begin n_err++; $display("FAIL bp_release got %b want 0100", rdy_act[0]); end
      advance();
      n_vec++;
      if (out_act[0] !== exp_out(0)) begin n_err++; $display("FAIL bp_out cyc %0d got %h want %h", j, out_act[0], exp_out(0)); end
    end
    idle_all();
    advance();
  endtask
  task automatic test_wrap3();
    logic [3:0] er;
    v_in[1] = 4'b0101; l_in[1] = 4'b0111; r_in[1] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 3; i++) d_in[1][i] = rdata(1);
      #1; er = model_ready(1);
      n_vec++;
      if (rdy_act[1] !== er) begin n_err++; $display("FAIL wrap_ready got %b want %b", rdy_act[1], er); end
      advance();
      n_vec++;
      if (out_act[1] !== exp_out(1)) begin n_err++; $display("FAIL wrap_out got %h want %h", out_act[1], exp_out(1)); end
      n_vec++;
      if (b_oc !== 2'(j % 2 * 2)) begin n_err++; $display("FAIL wrap_chosen beat %0d got %0d want %0d", j, b_oc, j % 2 * 2); end
    end
    idle_all();
    advance();
  endtask
  task automatic test_reset_locked();
    v_in[0] = 4'b0100; l_in[0] = 4'b0000; d_in[0][2] = rdata(0);
    advance();
    n_vec++;
    if ({a_ov, a_oc} !== 3'b110) begin n_err++; $display("FAIL lock_setup got %b want 110", {a_ov, a_oc}); end
    v_in[0] = 4'hF; l_in[0] = 4'hF;
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (out_act[0] !== 68'b0) begin n_err++; $display("FAIL async_reset_out got %h want 0", out_act[0]); end
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_vec++;
    if (rdy_act[0] !== 4'b0001) begin n_err++; $display("FAIL post_reset_ready got %b want 0001", rdy_act[0]); end
    advance();
    n_vec++;
    if (out_act[0] !== exp_out(0) || a_oc !== 2'd0) begin n_err++; $display("FAIL post_reset_out got %h want %h", out_act[0], exp_out(0)); end
    idle_all();
    advance();
  endtask
  task automatic test_single();
    logic [7:0] stream[12];
    logic [7:0] q[$];
    int sent;
    logic [3:0] er;
    sent = 0;
    stream[0] = 8'hA5; stream[1] = 8'h3C;
    for (int i = 2; i < 12; i++) stream[i] = 8'($urandom);
    for (int cyc = 0; cyc < 300 && (sent < 12 || q.size() != 0 || c_ov); cyc++) begin
      r_in[2] = $urandom_range(0, 1) == 1;
      if (c_ov && r_in[2]) begin
        n_vec++;
        if (q.size() == 0) begin n_err++; $display("FAIL single_extra got %h want none", c_od); end
        else begin
          if (c_od !== q[0]) begin n_err++; $display("FAIL single_order got %h want %h", c_od, q[0]); end
          void'(q.pop_front());
        end
      end
      v_in[2] = {3'b0, sent < 12 && $urandom_range(0, 3) != 0};
      d_in[2][0] = {56'b0, stream[sent < 12 ? sent : 0]};
      l_in[2] = {3'b0, 1'($urandom)};
      #1; er = model_ready(2);
      n_vec++;
      if (rdy_act[2] !== er) begin n_err++; $display("FAIL single_ready got %b want %b", rdy_act[2], er); end
      if (v_in[2][0] && c_rdy) begin q.push_back(stream[sent]); sent++; end
      advance();
      n_vec++;
      if (out_act[2] !== exp_out(2)) begin n_err++; $display("FAIL single_out got %h want %h", out_act[2], exp_out(2)); end
    end
    n_vec++;
    if (sent != 12 || q.size() != 0) begin n_err++; $display("FAIL single_done sent %0d pending %0d want 12 0", sent, q.size()); end
    idle_all();
    advance();
  endtask
  task automatic test_random();
    logic [3:0] er;
    for (int j = 0; j < 400; j++) begin
      for (int k = 0; k < 3; k++) begin
        v_in[k] = (4'($urandom) | 4'($urandom)) & 4'((1 << nin(k)) - 1);
        l_in[k] = 4'($urandom) & 4'((1 << nin(k)) - 1);
        r_in[k] = $urandom_range(0, 3) != 0;
        for (int i = 0; i < 4; i++) d_in[k][i] = i < nin(k) ? rdata(k) : 64'b0;
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        er = model_ready(k);
        n_vec++;
        if (rdy_act[k] !== er) begin n_err++; $display("FAIL rand_ready[%0d] cyc %0d got %b want %b", k, j, rdy_act[k], er); end
      end
      advance();
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (out_act[k] !== exp_out(k)) begin n_err++; $display("FAIL rand_out[%0d] cyc %0d got %h want %h", k, j, out_act[k], exp_out(k)); end
      end
    end
    idle_all();
  endtask
  initial begin
    reset = 1'b0;
    model_reset();
    idle_all();
    repeat (2) @(negedge clock);
    test_reset();
    test_round_robin();
    test_burst();
    test_backpressure();
    test_wrap3();
    test_reset_locked();
    test_single();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Parametrised N-input round-robin arbiter with burst locking and a registered output stage.
- Generalises the single-input pass-through arbiter: N requesters share one downstream ready/valid channel.
- A multi-beat burst holds the grant until its last beat.
- Sits between multiple client queues and one shared downstream port, such as a memory request channel or a writeback bus.

Parameters:
- N_IN, 4, number of input channels (>=1).
- DATA_W, 64, payload width per beat.
- IDX_W, $clog2(N_IN) min 1, width of the chosen index (derived, not overridable).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- io_in_valid  input  N_IN  per-input beat valid.
- io_in_ready  output  N_IN  per-input beat accept.
- io_in_bits_data  input  N_IN*DATA_W  per-input payload, input i at bits [i*DATA_W +: DATA_W].
- io_in_bits_last  input  N_IN  per-input last-beat-of-burst flag.
- io_out_valid  output  1  output register holds a beat.
- io_out_ready  input  1  downstream accept.
- io_out_bits_data  output  DATA_W  registered payload.
- io_out_bits_last  output  1  registered last flag.
- io_chosen  output  IDX_W  registered index of the input that supplied the current output beat.

Behaviour:
- Reset (reset=0, async): state=IDLE, ptr=0, io_out_valid=0, io_out_bits_data=0, io_out_bits_last=0, io_chosen=0, lock_idx=0.
- io_in_ready is all-zero while reset is asserted.
- Pipeline accept:
  - acc = !io_out_valid || io_out_ready.
  - A beat moves from input i when io_in_valid[i] && io_in_ready[i].
  - That beat is visible on io_out_* the next cycle: latency 1, throughput 1 beat/cycle.
- Output register:
  - On an input fire it loads data, last and chosen, and io_out_valid stays 1.
  - Else, if io_out_ready, io_out_valid clears to 0.
  - Else it holds. Payload must not change while io_out_valid && !io_out_ready.
- State IDLE:
  - If acc, grant g = first i with io_in_valid[i], scanning ptr, ptr+1, ..., N_IN-1, 0, ..., ptr-1.
  - io_in_ready[g]=1; all other readies are 0.
  - If no input is valid, all readies are 0.
  - On fire with last=1: ptr <= (g+1) mod N_IN; stay IDLE.
  - On fire with last=0: lock_idx <= g; go to LOCKED; ptr unchanged.
- State LOCKED:
  - io_in_ready[lock_idx] = acc; all others are 0 regardless of their valid.
  - On fire with last=1: ptr <= (lock_idx+1) mod N_IN; go to IDLE.
  - Gaps (locked input not valid) keep LOCKED indefinitely, with no timeout.
- Readiness dependencies:
  - io_in_ready may depend combinationally on io_out_ready and on io_in_valid of other inputs.
  - io_in_ready[i] must not depend on io_in_bits_*.
- Wrap-around: ptr increments modulo N_IN; N_IN not a power of two must wrap at N_IN-1 -> 0.
- N_IN=1: degenerates to a registered pass-through; ptr and io_chosen stay 0; locking is harmless.
- Simultaneous events:
  - Output drain and new load in the same cycle is a full-rate transfer.
  - Requests arriving in the grant cycle are arbitrated on the current ptr only.
- Reset mid-burst: LOCKED is abandoned immediately; the in-flight output beat is dropped (io_out_valid=0). Upstream must also be reset.

Decomposition:
- Package rr_lock_arbiter_pkg:
  - arb_state_e enum {IDLE, LOCKED}.
  - Function for the rotate-and-priority-select index.
  - IDX_W derivation constant function.
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: req[N_IN], ptr[IDX_W].
  - Outputs: one-hot grant and index.
  - Uses a double-width mask/priority-encode.
  - Keeps the FSM file focused on lock/ptr/output register.

Test Plan:
- Reset then all 4 inputs valid, last=1, io_out_ready=1 constantly -> io_chosen sequence 0,1,2,3,0,... one beat per cycle, first io_out_valid one cycle after first grant.
- Input 1 sends 3-beat burst (last on beat 3) while inputs 0,2 valid -> io_chosen=1,1,1, then 2, then 0. No interleaving even when input 1 deasserts valid for 2 cycles mid-burst.
- io_out_ready held 0 for 5 cycles with io_out_valid=1 -> io_out_bits_* stable, all io_in_ready=0. After release, the next beat loads in the same cycle as the drain.
- N_IN=3, inputs 0 and 2 valid, last=1 -> alternates 0,2,0,2, proving wrap from 2 to 0 with the ptr skipping idle input 1.
- Assert reset (0) during LOCKED with io_out_valid=1 -> io_out_valid=0 asynchronously, ptr=0. After release, input 0 wins even if the previous lock_idx was 2.
- N_IN=1, DATA_W=8, stream 0xA5, 0x3C with io_out_ready random -> outputs in order, io_chosen=0, no beat lost or duplicated.
